// File: rtl/pipeline_exec_controller.sv
// Run/step/halt sequencer driving the pipeline, fetch and decoder enables.
// Enables are combinational from state and i_halt; commands are taken only in IDLE and RUN.
module pipeline_exec_controller #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  input  logic [1:0]       i_cmd,
  output logic             o_cmd_ready,
  input  logic             i_halt,
  output logic             o_pipe_en,
  output logic             o_fetch_en,
  output logic             o_ctrl_en,
  output logic [2:0]       o_state,
  output logic [CNT_W-1:0] o_cycle_cnt,
  output logic             o_done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  localparam logic [1:0] CMD_RUN  = 2'b01;
  localparam logic [1:0] CMD_STEP = 2'b10;
  localparam logic [1:0] CMD_STOP = 2'b11;

  state_t          state;
  state_t          state_nxt;
  logic [DW-1:0]   drain_cnt;
  logic [DW-1:0]   drain_cnt_nxt;
  logic            cmd_fire;
  logic            executing;

  assign executing   = (state == S_RUN) || (state == S_STEP);
  assign o_pipe_en   = executing || (state == S_DRAIN);
  // HALT itself becomes a bubble and the PC stays on its successor.
  assign o_fetch_en  = executing && !i_halt;
  assign o_ctrl_en   = executing && !i_halt;
  assign o_cmd_ready = (state == S_IDLE) || (state == S_RUN);
  assign o_done      = (state == S_DONE);
  assign o_state     = state;
  assign cmd_fire    = i_cmd_valid && o_cmd_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= S_IDLE;
      drain_cnt   <= '0;
      o_cycle_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
      if (o_pipe_en && (o_cycle_cnt != {CNT_W{1'b1}}))
        o_cycle_cnt <= o_cycle_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = drain_cnt;
    case (state)
      S_IDLE: begin
        if (cmd_fire && (i_cmd == CMD_RUN))
          state_nxt = S_RUN;
        else if (cmd_fire && (i_cmd == CMD_STEP))
          state_nxt = S_STEP;
      end
      S_RUN: begin
        // A HALT in ID wins over a STOP arriving in the same cycle.
        if (i_halt) begin
          state_nxt     = S_DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
        end else if (cmd_fire && (i_cmd == CMD_STOP)) begin
          state_nxt = S_IDLE;
        end
      end
      S_STEP: begin
        if (i_halt) begin
          state_nxt     = S_DRAIN;
          drain_cnt_nxt = DRAIN_LOAD;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == '0)
          state_nxt = S_DONE;
        else
          drain_cnt_nxt = drain_cnt - DW'(1);
      end
      S_DONE: state_nxt = S_DONE;
      default: begin
        state_nxt     = S_IDLE;
        drain_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_pipeline_exec_controller.sv
// Directed bench: stimulus queues hand-computed per-cycle expectations, a negedge monitor checks them.
module tb_pipeline_exec_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = 2'b00;
  logic        halt = 1'b0;

  logic        cmd_ready, pipe_en, fetch_en, ctrl_en, done;
  logic [2:0]  state;
  logic [31:0] cycle_cnt;
  logic        cmd_ready4, pipe_en4, fetch_en4, ctrl_en4, done4;
  logic [2:0]  state4;
  logic [3:0]  cycle_cnt4;

  localparam logic [1:0] NOP = 2'b00, RUN = 2'b01, STEP = 2'b10, STOP = 2'b11;
  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_STEP = 3'd2, S_DRAIN = 3'd3, S_DONE = 3'd4;
  // flag order: {pipe_en, fetch_en, ctrl_en, cmd_ready, done}
  localparam logic [4:0] F_IDLE  = 5'b00010;
  localparam logic [4:0] F_RUN   = 5'b11110;
  localparam logic [4:0] F_RUNH  = 5'b10010;
  localparam logic [4:0] F_STEP  = 5'b11100;
  localparam logic [4:0] F_STEPH = 5'b10000;
  localparam logic [4:0] F_DRAIN = 5'b10000;
  localparam logic [4:0] F_DONE  = 5'b00001;

  always #5 clk = ~clk;

  pipeline_exec_controller #(.DRAIN_CYCLES(3), .CNT_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(cmd_ready),
    .i_halt(halt), .o_pipe_en(pipe_en), .o_fetch_en(fetch_en), .o_ctrl_en(ctrl_en),
    .o_state(state), .o_cycle_cnt(cycle_cnt), .o_done(done)
  );

  pipeline_exec_controller #(.DRAIN_CYCLES(3), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .i_cmd(cmd), .o_cmd_ready(cmd_ready4),
    .i_halt(halt), .o_pipe_en(pipe_en4), .o_fetch_en(fetch_en4), .o_ctrl_en(ctrl_en4),
    .o_state(state4), .o_cycle_cnt(cycle_cnt4), .o_done(done4)
  );

  typedef struct {
    int          id;
    logic [2:0]  st;
    logic [4:0]  fl;
    logic [31:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t q[$];
  int   vec_id = 0;
  int   applied = 0;
  int   miscompares = 0;

  // One clock of stimulus; when chk is set, the expected outputs for this cycle are queued.
  task automatic cyc(input logic v, input logic [1:0] c, input logic h, input logic r,
                     input bit chk, input logic [2:0] st, input logic [4:0] fl, input int cnt);
    exp_t e;
    @(posedge clk);
    #1;
    cmd_valid = v;
    cmd       = c;
    halt      = h;
    rst       = r;
    if (chk) begin
      e.id   = vec_id;
      e.st   = st;
      e.fl   = fl;
      e.cnt  = cnt;
      e.cnt4 = (cnt > 15) ? 4'd15 : cnt[3:0];
      q.push_back(e);
      vec_id++;
    end
  endtask

  always @(negedge clk) begin
    exp_t       m;
    logic [4:0] fl_act;
    logic [4:0] fl4_act;
    if (q.size() > 0) begin
      m       = q.pop_front();
      fl_act  = {pipe_en, fetch_en, ctrl_en, cmd_ready, done};
      fl4_act = {pipe_en4, fetch_en4, ctrl_en4, cmd_ready4, done4};
      applied++;
      if (state !== m.st || fl_act !== m.fl || cycle_cnt !== m.cnt ||
          state4 !== m.st || fl4_act !== m.fl || cycle_cnt4 !== m.cnt4) begin
        miscompares++;
        $display("FAIL vec%0d: got state=%0d flags=%b cnt=%0d | w4 state=%0d flags=%b cnt=%0d ; want state=%0d flags=%b cnt=%0d cnt4=%0d",
                 m.id, state, fl_act, cycle_cnt, state4, fl4_act, cycle_cnt4,
                 m.st, m.fl, m.cnt, m.cnt4);
      end
    end
  end

  initial begin
    // Reset, then idle; a HALT seen while idle must be ignored.
    cyc(0, NOP, 0, 1, 0, S_IDLE, F_IDLE, 0);
    cyc(0, NOP, 0, 0, 1, S_IDLE, F_IDLE, 0);
    cyc(0, NOP, 0, 0, 1, S_IDLE, F_IDLE, 0);
    cyc(0, STOP, 0, 0, 1, S_IDLE, F_IDLE, 0);
    cyc(0, NOP, 1, 0, 1, S_IDLE, F_IDLE, 0);
    cyc(0, NOP, 0, 0, 1, S_IDLE, F_IDLE, 0);

    // RUN at t, HALT at t+6, drain three cycles, park in DONE with count 9.
    cyc(1, RUN, 0, 0, 1, S_IDLE, F_IDLE, 0);
    for (int i = 0; i < 5; i++) cyc(0, NOP, 0, 0, 1, S_RUN, F_RUN, i);
    cyc(0, NOP, 1, 0, 1, S_RUN, F_RUNH, 5);
    cyc(0, NOP, 0, 0, 1, S_DRAIN, F_DRAIN, 6);
    cyc(1, STOP, 1, 0, 1, S_DRAIN, F_DRAIN, 7);
    cyc(1, RUN, 0, 0, 1, S_DRAIN, F_DRAIN, 8);
    cyc(0, NOP, 0, 0, 1, S_DONE, F_DONE, 9);
    cyc(1, STEP, 0, 0, 1, S_DONE, F_DONE, 9);
    cyc(1, RUN, 0, 0, 1, S_DONE, F_DONE, 9);

    // Three single steps; a command during the STEP cycle is dropped.
    cyc(0, NOP, 0, 1, 0, S_IDLE, F_IDLE, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, STEP, 0, 0, 1, S_IDLE, F_IDLE, k);
      cyc(k == 1, RUN, 0, 0, 1, S_STEP, F_STEP, k);
      cyc(0, NOP, 0, 0, 1, S_IDLE, F_IDLE, k + 1);
      cyc(0, NOP, 0, 0, 1, S_IDLE, F_IDLE, k + 1);
    end

    // HALT during a STEP goes to DRAIN.
    cyc(1, STEP, 0, 0, 1, S_IDLE, F_IDLE, 3);
    cyc(0, NOP, 1, 0, 1, S_STEP, F_STEPH, 3);
    cyc(0, NOP, 0, 0, 1, S_DRAIN, F_DRAIN, 4);
    cyc(0, NOP, 0, 0, 1, S_DRAIN, F_DRAIN, 5);
    cyc(0, NOP, 0, 0, 1, S_DRAIN, F_DRAIN, 6);
    cyc(0, NOP, 0, 0, 1, S_DONE, F_DONE, 7);

    // RUN, STOP at t+4, resume from 4, then STOP+HALT together, reset mid-DRAIN.
    cyc(0, NOP, 0, 1, 0, S_IDLE, F_IDLE, 0);
    cyc(1, RUN, 0, 0, 1, S_IDLE, F_IDLE, 0);
    cyc(0, NOP, 0, 0, 1, S_RUN, F_RUN, 0);
    cyc(1, RUN, 0, 0, 1, S_RUN, F_RUN, 1);
    cyc(0, NOP, 0, 0, 1, S_RUN, F_RUN, 2);
    cyc(1, STOP, 0, 0, 1, S_RUN, F_RUN, 3);
    cyc(0, NOP, 0, 0, 1, S_IDLE, F_IDLE, 4);
    cyc(1, RUN, 0, 0, 1, S_IDLE, F_IDLE, 4);
    cyc(0, NOP, 0, 0, 1, S_RUN, F_RUN, 4);
    cyc(1, STEP, 0, 0, 1, S_RUN, F_RUN, 5);
    cyc(1, STOP, 1, 0, 1, S_RUN, F_RUNH, 6);
    cyc(0, NOP, 0, 0, 1, S_DRAIN, F_DRAIN, 7);
    cyc(0, NOP, 0, 1, 1, S_DRAIN, F_DRAIN, 8);
    cyc(0, NOP, 0, 0, 1, S_IDLE, F_IDLE, 0);
    cyc(0, NOP, 0, 0, 1, S_IDLE, F_IDLE, 0);

    // 20-cycle run: the 32-bit counter reaches 20, the 4-bit one sticks at 15.
    cyc(1, RUN, 0, 0, 1, S_IDLE, F_IDLE, 0);
    for (int i = 0; i < 20; i++) cyc(i == 19, STOP, 0, 0, 1, S_RUN, F_RUN, i);
    cyc(0, NOP, 0, 0, 1, S_IDLE, F_IDLE, 20);
    cyc(0, NOP, 0, 0, 0, S_IDLE, F_IDLE, 20);

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_queue: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_exec_controller.md
Name: pipeline_exec_controller

Overview:
Run/step/halt sequencer for the 5-stage MIPS pipeline. It sits between the debug command interface and the datapath, and generates the global pipeline enable, the fetch enable and the decoder enable (the latter drives the control unit's i_enable). When a HALT instruction reaches ID, it stops fetch, drains the instructions already ahead of HALT through WB, then parks in DONE with a cycle count for the debug unit.

Parameters:
DRAIN_CYCLES, 3, enabled cycles spent in DRAIN after the HALT cycle (EX/MEM/WB retirement)
CNT_W, 32, width of executed-cycle counter

Ports:
i_clk  in  1  clock; all state updates on rising edge
i_rst  in  1  reset; one clock, synchronous, active-high; returns block to IDLE
i_cmd_valid  in  1  command strobe, accepted when o_cmd_ready=1
i_cmd  in  2  00 NOP, 01 RUN, 10 STEP, 11 STOP
o_cmd_ready  out  1  high in IDLE and RUN only
i_halt  in  1  HALT opcode (6'b111111) decoded in ID this cycle
o_pipe_en  out  1  enable for PC, all pipeline registers and register file write
o_fetch_en  out  1  PC update / IF-ID load enable
o_ctrl_en  out  1  decoder enable; low inserts a bubble into ID/EX
o_state  out  3  IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4
o_cycle_cnt  out  CNT_W  number of cycles with o_pipe_en=1
o_done  out  1  high in DONE

Behaviour:
- Reset: state=IDLE, drain counter=0, o_cycle_cnt=0, all enables 0, o_done=0, o_cmd_ready=1. Reset has priority over every event, including mid-DRAIN and in DONE.
- Enables are combinational from state and i_halt:
  - o_pipe_en = (RUN|STEP|DRAIN)
  - o_fetch_en = (RUN|STEP) & ~i_halt
  - o_ctrl_en = (RUN|STEP) & ~i_halt
  - The HALT instruction itself is therefore turned into a bubble, and PC holds at HALT's successor.
- IDLE (paused): all enables 0; i_halt ignored.
  - RUN cmd -> RUN.
  - STEP cmd -> STEP.
  - STOP/NOP -> stay.
- RUN: enables on.
  - i_halt=1 -> DRAIN, load drain counter with DRAIN_CYCLES-1.
  - Else STOP cmd -> IDLE (pipeline freezes from next cycle).
  - RUN/STEP/NOP cmds accepted and ignored.
  - i_halt beats STOP in the same cycle.
- STEP: lasts exactly one cycle with enables on; o_cmd_ready=0.
  - i_halt=1 -> DRAIN.
  - Else -> IDLE.
  - Latency: STEP accepted at cycle t gives o_pipe_en=1 at t+1 only, IDLE at t+2.
- DRAIN: o_pipe_en=1, fetch/ctrl 0, o_cmd_ready=0 (commands dropped).
  - Counter decrements each cycle.
  - At counter=0 -> DONE, so DRAIN lasts exactly DRAIN_CYCLES cycles.
  - i_halt ignored.
  - DRAIN_CYCLES=0 is illegal.
- DONE: all enables 0, o_done=1, o_cmd_ready=0; left only by i_rst.
- o_cycle_cnt: +1 on every cycle with o_pipe_en=1 (the HALT cycle included); saturates at 2^CNT_W-1, never wraps; holds otherwise.
- Illegal/unused state encodings recover to IDLE on the next clock.

Test Plan:
- Reset then idle 5 cycles -> o_state=0, all enables 0, o_cycle_cnt=0, o_cmd_ready=1.
- RUN at t, i_halt pulsed at t+6:
  - o_pipe_en=1 for t+1..t+9; fetch/ctrl low at t+6 only (HALT cycle), then low throughout.
  - DRAIN t+7..t+9, DONE t+10, o_cycle_cnt=9, o_done=1.
- STEP three times, gaps of 2 cycles -> o_pipe_en exactly one cycle each, o_state returns to 0, o_cycle_cnt=3.
- RUN, then STOP at t+4 -> IDLE at t+5, o_cycle_cnt=4; RUN again resumes counting from 4.
- STOP and i_halt same cycle in RUN -> DRAIN, not IDLE. A command presented in DRAIN/DONE -> o_cmd_ready=0, no effect.
- Edge cases:
  - i_rst asserted in 2nd DRAIN cycle -> IDLE and count=0 next cycle.
  - CNT_W=4 run of 20 cycles -> o_cycle_cnt saturates at 15.
